// File: rtl/jstk_spi_responder_if.sv
// SPI link between the joystick master and the PmodJSTK responder.
// Mode 0, MSB first; ss is active low.
interface jstk_spi_responder_if;
  logic sclk;
  logic ss;
  logic mosi;
  logic miso;

  modport master (
    output sclk,
    output ss,
    output mosi,
    input  miso
  );

  modport slave (
    input  sclk,
    input  ss,
    input  mosi,
    output miso
  );
endinterface

// File: rtl/jstk_spi_responder.sv
// PmodJSTK emulator: answers each 5-byte SPI frame with an X/Y/button snapshot
// and latches the LED command carried in the master's first byte.
module jstk_spi_responder #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  jstk_spi_responder_if.slave        spi,
  input  logic [9:0]                 x_pos,
  input  logic [9:0]                 y_pos,
  input  logic [2:0]                 buttons,
  output logic [1:0]                 led,
  output logic                       frame_done,
  output logic                       frame_error
);

  localparam logic [5:0] FRAME_BITS = 6'd40;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_e;

  logic [SYNC_STAGES-1:0] sclk_sync_q;
  logic [SYNC_STAGES-1:0] ss_sync_q;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic                   sclk_hist_q;
  logic                   ss_hist_q;

  logic sclk_s, ss_s, mosi_s;
  logic sclk_rise, sclk_fall, ss_rise, ss_fall;

  state_e      state_q, state_d;
  logic [5:0]  bit_cnt_q, bit_cnt_d;
  logic [39:0] tx_shift_q, tx_shift_d;
  logic [39:0] rx_shift_q, rx_shift_d;
  logic [1:0]  led_q, led_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        fall_pend_q, fall_pend_d;
  logic [39:0] payload;

  // Synchronizers plus one history flop per edge-detected line.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sclk_sync_q <= '0;
      ss_sync_q   <= '1;
      mosi_sync_q <= '0;
      sclk_hist_q <= 1'b0;
      ss_hist_q   <= 1'b1;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi.sclk};
      ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], spi.ss};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi.mosi};
      sclk_hist_q <= sclk_s;
      ss_hist_q   <= ss_s;
    end
  end

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign ss_s      = ss_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_hist_q;
  assign sclk_fall = ~sclk_s & sclk_hist_q;
  assign ss_rise   = ss_s & ~ss_hist_q;
  assign ss_fall   = ~ss_s & ss_hist_q;

  assign payload = {x_pos[7:0], 6'b0, x_pos[9:8],
                    y_pos[7:0], 6'b0, y_pos[9:8],
                    5'b0, buttons};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      bit_cnt_q   <= '0;
      tx_shift_q  <= '0;
      rx_shift_q  <= '0;
      led_q       <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      fall_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      tx_shift_q  <= tx_shift_d;
      rx_shift_q  <= rx_shift_d;
      led_q       <= led_d;
      done_q      <= done_d;
      err_q       <= err_d;
      fall_pend_q <= fall_pend_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    tx_shift_d  = tx_shift_q;
    rx_shift_d  = rx_shift_q;
    led_d       = led_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    fall_pend_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        bit_cnt_d  = '0;
        tx_shift_d = '0;
        if (ss_fall || fall_pend_q) begin
          tx_shift_d = payload;
          state_d    = S_SHIFT;
        end
      end

      S_SHIFT: begin
        if (ss_rise) begin
          if (bit_cnt_q == FRAME_BITS) begin
            state_d = S_DONE;
          end else begin
            err_d      = 1'b1;
            bit_cnt_d  = '0;
            tx_shift_d = '0;
            state_d    = S_IDLE;
          end
        end else begin
          if (sclk_rise && (bit_cnt_q < FRAME_BITS)) begin
            rx_shift_d = {rx_shift_q[38:0], mosi_s};
            bit_cnt_d  = bit_cnt_q + 6'd1;
          end
          // miso is the tx MSB; shifting zeros in leaves it low after bit 0.
          if (sclk_fall) begin
            if (bit_cnt_q < FRAME_BITS) begin
              tx_shift_d = {tx_shift_q[38:0], 1'b0};
            end else begin
              tx_shift_d = '0;
            end
          end
        end
      end

      S_DONE: begin
        done_d      = 1'b1;
        tx_shift_d  = '0;
        bit_cnt_d   = '0;
        fall_pend_d = ss_fall;
        if (rx_shift_q[39:34] == 6'b100000) begin
          led_d = rx_shift_q[33:32];
        end
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign spi.miso    = tx_shift_q[39];
  assign led         = led_q;
  assign frame_done  = done_q;
  assign frame_error = err_q;

endmodule

// File: tb/tb_jstk_spi_responder.sv
// Directed and randomized frames against a byte-level model of the PmodJSTK reply.
module tb_jstk_spi_responder;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] x_pos;
  logic [9:0] y_pos;
  logic [2:0] buttons;
  logic [1:0] led;
  logic       frame_done;
  logic       frame_error;

  always #5 clk = ~clk;

  jstk_spi_responder_if spi ();

  jstk_spi_responder #(.SYNC_STAGES(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .spi         (spi),
    .x_pos       (x_pos),
    .y_pos       (y_pos),
    .buttons     (buttons),
    .led         (led),
    .frame_done  (frame_done),
    .frame_error (frame_error)
  );

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;
  int err_cnt  = 0;
  int d0, e0;

  logic       got [0:63];
  logic [9:0] snap_x, snap_y;
  logic [2:0] snap_b;
  logic [1:0] led_model;
  logic [7:0] tx0;

  always @(negedge clk) begin
    if (frame_done === 1'b1) done_cnt++;
    if (frame_error === 1'b1) err_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_byte(input int idx, input logic [9:0] x,
                                          input logic [9:0] y, input logic [2:0] b);
    int xi, yi, bi;
    xi = int'(x);
    yi = int'(y);
    bi = int'(b);
    case (idx)
      0:       return 8'(xi % 256);
      1:       return 8'(xi / 256);
      2:       return 8'(yi % 256);
      3:       return 8'(yi / 256);
      4:       return 8'(bi);
      default: return 8'h00;
    endcase
  endfunction

  // Master side of one frame; records miso bit k in got[k].
  task automatic frame(input int nbits, input logic [7:0] first, input int chg_bit,
                       input logic [9:0] chg_x, input bit raise_ss);
    snap_x = x_pos;
    snap_y = y_pos;
    snap_b = buttons;
    for (int k = 0; k < 64; k++) got[k] = 1'bx;
    spi.ss = 1'b0;
    repeat (6) @(negedge clk);
    for (int k = 0; k < nbits; k++) begin
      spi.mosi = (k < 8) ? first[7-k] : 1'b0;
      repeat (4) @(negedge clk);
      got[k] = spi.miso;
      @(negedge clk);
      spi.sclk = 1'b1;
      repeat (5) @(negedge clk);
      spi.sclk = 1'b0;
      if (k == chg_bit) x_pos = chg_x;
    end
    repeat (5) @(negedge clk);
    if (raise_ss) spi.ss = 1'b1;
    repeat (8) @(negedge clk);
    if (raise_ss && nbits >= 40 && (int'(first) / 4) == 32)
      led_model = 2'(int'(first) % 4);
  endtask

  task automatic check_payload(input string tag, input int nbits);
    logic [7:0] b;
    logic [7:0] tail;
    for (int i = 0; i < 5; i++) begin
      if (i * 8 + 8 <= nbits) begin
        b = '0;
        for (int j = 0; j < 8; j++) b = {b[6:0], got[i*8+j]};
        chk($sformatf("%s_byte%0d", tag, i), 32'(b), 32'(exp_byte(i, snap_x, snap_y, snap_b)));
      end
    end
    if (nbits > 40) begin
      tail = '0;
      for (int k = 40; k < nbits; k++) tail = {tail[6:0], got[k]};
      chk($sformatf("%s_overrun_bits", tag), 32'(tail), 32'h0);
    end
  endtask

  initial begin
    rst       = 1'b0;
    spi.ss    = 1'b1;
    spi.sclk  = 1'b0;
    spi.mosi  = 1'b0;
    x_pos     = 10'h2A5;
    y_pos     = 10'h13C;
    buttons   = 3'b101;
    led_model = 2'b00;
    repeat (3) @(negedge clk);
    chk("reset_miso", 32'(spi.miso), 32'h0);
    chk("reset_led", 32'(led), 32'h0);
    chk("reset_done", 32'(frame_done), 32'h0);
    chk("reset_err", 32'(frame_error), 32'h0);
    rst = 1'b1;
    repeat (5) @(negedge clk);

    // Full frame with LED command 0x83.
    d0 = done_cnt; e0 = err_cnt;
    frame(40, 8'h83, -1, 10'h0, 1'b1);
    check_payload("full", 40);
    chk("full_bytes_literal", {got[0], got[1], got[2], got[3], got[4], got[5], got[6], got[7]}, 32'hA5);
    chk("full_done", 32'(done_cnt - d0), 32'd1);
    chk("full_err", 32'(err_cnt - e0), 32'd0);
    chk("full_led", 32'(led), 32'(led_model));
    chk("full_led_literal", 32'(led), 32'h3);

    // Snapshot: x_pos changes during byte0.
    frame(40, 8'h00, 2, 10'h000, 1'b1);
    check_payload("snap", 40);
    frame(40, 8'h00, -1, 10'h0, 1'b1);
    check_payload("snap_next", 40);

    // Non-command first byte keeps led.
    d0 = done_cnt;
    frame(40, 8'h40, -1, 10'h0, 1'b1);
    chk("noncmd_done", 32'(done_cnt - d0), 32'd1);
    chk("noncmd_led", 32'(led), 32'h3);

    // Abort after 17 clocks.
    d0 = done_cnt; e0 = err_cnt;
    frame(17, 8'h81, -1, 10'h0, 1'b1);
    check_payload("abort", 17);
    chk("abort_err", 32'(err_cnt - e0), 32'd1);
    chk("abort_done", 32'(done_cnt - d0), 32'd0);
    chk("abort_led", 32'(led), 32'(led_model));
    x_pos = 10'h3FF; y_pos = 10'h001; buttons = 3'b010;
    frame(40, 8'h82, -1, 10'h0, 1'b1);
    check_payload("after_abort", 40);
    chk("after_abort_led", 32'(led), 32'(led_model));

    // Overrun: 45 clocks.
    d0 = done_cnt;
    frame(45, 8'h81, -1, 10'h0, 1'b1);
    check_payload("overrun", 45);
    chk("overrun_done", 32'(done_cnt - d0), 32'd1);
    chk("overrun_led", 32'(led), 32'(led_model));

    // Reset in the middle of a frame.
    d0 = done_cnt; e0 = err_cnt;
    frame(24, 8'h83, -1, 10'h0, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_miso", 32'(spi.miso), 32'h0);
    chk("midrst_led", 32'(led), 32'h0);
    @(negedge clk);
    spi.ss    = 1'b1;
    rst       = 1'b1;
    led_model = 2'b00;
    repeat (8) @(negedge clk);
    chk("midrst_no_err", 32'(err_cnt - e0), 32'd0);
    chk("midrst_no_done", 32'(done_cnt - d0), 32'd0);
    frame(40, 8'h41, -1, 10'h0, 1'b1);
    check_payload("after_rst", 40);
    chk("after_rst_led", 32'(led), 32'(led_model));

    // Randomized frames.
    for (int n = 0; n < 8; n++) begin
      x_pos   = 10'($urandom_range(0, 1023));
      y_pos   = 10'($urandom_range(0, 1023));
      buttons = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 0) tx0 = 8'(128 + $urandom_range(0, 3));
      else                           tx0 = 8'($urandom_range(0, 255));
      d0 = done_cnt; e0 = err_cnt;
      frame(40, tx0, -1, 10'h0, 1'b1);
      check_payload($sformatf("rand%0d", n), 40);
      chk($sformatf("rand%0d_done", n), 32'(done_cnt - d0), 32'd1);
      chk($sformatf("rand%0d_err", n), 32'(err_cnt - e0), 32'd0);
      chk($sformatf("rand%0d_led", n), 32'(led), 32'(led_model));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/jstk_spi_responder.md
# jstk_spi_responder

SPI slave that emulates a Digilent PmodJSTK on the far end of the joystick SPI link. It answers each 5-byte frame from the joystick master with a snapshot of X, Y and button state, and captures the master's LED command byte. It is used as a board-to-board joystick source and as the bus model in system simulation of the game top.

## Interface

Parameters:
- SYNC_STAGES, 2: flip-flop stages on each of sclk, ss and mosi before edge detection; legal values are 2 or 3.

Ports:
- clk  in  1  system clock (100 MHz); every register is clocked on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- sclk  in  1  SPI clock from the master; asynchronous to clk.
- ss  in  1  slave select from the master, active low; asynchronous.
- mosi  in  1  master-out data; asynchronous.
- miso  out  1  slave-out data.
- x_pos  in  10  joystick X value, 0–1023.
- y_pos  in  10  joystick Y value, 0–1023.
- buttons  in  3  bit0 is the stick button, bit1 is button 1, bit2 is button 2.
- led  out  2  LED state commanded by the master.
- frame_done  out  1  one-cycle pulse when a complete 40-bit frame ends.
- frame_error  out  1  one-cycle pulse when a frame is aborted.

## Operation

SPI format:
- Mode 0 (CPOL=0, CPHA=0), MSB first.
- The slave samples mosi on the rising edge of sclk and changes miso on the falling edge of sclk.
- sclk, ss and mosi each pass through SYNC_STAGES synchronizer flops, then one history flop used for edge detection.
- Requirement on clk: clk ≥ 8× the sclk frequency.

Tx payload:
- Byte order: byte0 = x_pos[7:0], byte1 = {6'b0, x_pos[9:8]}, byte2 = y_pos[7:0], byte3 = {6'b0, y_pos[9:8]}, byte4 = {5'b0, buttons}.
- The 40-bit payload is captured in a single cycle when the falling edge of ss is detected. Input changes after that point do not affect the current frame.

State machine:
- IDLE: miso = 0 and the bit counter is 0. A detected falling edge of ss loads tx_shift with the payload, drives miso with payload bit 39, and moves to SHIFT.
- SHIFT:
  - On a detected sclk rise, rx_shift <= {rx_shift[38:0], mosi_sync} and bit_cnt increments, saturating at 40.
  - On a detected sclk fall with bit_cnt < 40, tx_shift shifts left by one and miso takes the new MSB.
  - On a sclk fall with bit_cnt = 40, miso = 0.
  - A detected rise of ss with bit_cnt = 40 moves to DONE.
  - A detected rise of ss with bit_cnt < 40 pulses frame_error for one cycle, leaves led unchanged, and returns to IDLE.
- DONE, which lasts one cycle:
  - frame_done pulses.
  - If rx byte0 [7:2] == 6'b100000, led <= rx byte0 [1:0]; otherwise led is unchanged.
  - The state returns to IDLE.

Boundary cases:
- sclk edges while ss is high are ignored.
- sclk pulses beyond 40 in a frame are ignored, and miso stays 0.
- A new ss fall arriving in the DONE cycle is honoured on the following cycle. The ss-fall event is held for one cycle so that it is not lost.
- bit_cnt is 6 bits wide and saturates at 40; it never wraps.

Reset:
- rst low, at any time including mid-frame, forces: state IDLE, miso 0, led 2'b00, frame_done 0, frame_error 0, bit_cnt 0, all shift and synchronizer registers 0.
- The synchronizer for ss resets to 1.
- After rst is released, the first frame must begin with a fresh ss fall. A frame that was already in progress is not resumed.

## Timing

- Pin-to-event latency is SYNC_STAGES+1 clk cycles, which is 3 at the default.
- miso changes 3 clk cycles after a pin-level sclk fall. It presents bit 39 3 cycles after the pin-level ss fall.
- The master must allow at least 4 clk cycles between the ss fall and the first sclk rise.
- rx sampling happens 3 cycles after a pin-level sclk rise. mosi must be stable for 4 clk cycles around that rise.
- frame_done is asserted 4 cycles after the pin-level ss rise, and led updates on the same clk edge.
- frame_error is asserted 3 cycles after the pin-level ss rise.
- miso never changes while sclk_sync is high.

## Test plan

- Full frame: x_pos=10'h2A5, y_pos=10'h13C, buttons=3'b101, master sends 8'h83 then 4×8'h00 -> miso bytes A5,02,3C,01,05. One frame_done pulse. led=2'b11.
- Snapshot: change x_pos to 10'h000 after byte0 has started -> remaining bytes are still from 10'h2A5. The next frame returns 00,00.
- Non-command byte: first byte 8'h40 -> frame_done pulses and led keeps its prior value 2'b11.
- Abort: ss rises after 17 sclk cycles -> frame_error pulses once, frame_done stays 0, led unchanged, and the next full frame is correct.
- Overrun: 45 sclk pulses in one frame -> bits 40–44 read 0 and exactly one frame_done pulse occurs.
- Reset mid-frame: rst low for 2 cycles after byte 2 -> miso=0 and led=00. A new frame after release returns a correct 5-byte payload.
